regfile_wb_sequencer: RTL
=========================

// Module: regfile_wb_sequencer
// PURPOSE
//  Writeback-side initiator for the 32x32 register file write port. Accepts
//  register write results over a valid/ready stream, buffers them in an
//  in-order FIFO, and issues at most one write per cycle onto
//  RegWrite/WriteReg/WriteData.
//  Sits between the execute/memory result path and the register file.
//  Optionally exposes a pending-write bypass lookup for operand forwarding.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of two, >= 2
//  DW     32  data width
//  AW     5   register index width
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      producer has a write result
//  in_ready   out  1      sequencer can accept this cycle
//  in_reg     in   AW     destination register index
//  in_data    in   DW     write data
//  wr_stall   in   1      hold drain; no new write issued while high
//  RegWrite   out  1      register file write enable (registered)
//  WriteReg   out  AW     register file write index (registered)
//  WriteData  out  DW     register file write data (registered)
//  count      out  clog2(DEPTH)+1  occupied FIFO entries
//  empty      out  1      count == 0
//  q_reg      in   AW     bypass lookup index (WB_BYPASS_EN only)
//  q_hit      out  1      pending write to q_reg exists
//  q_data     out  DW     youngest pending data for q_reg
// BEHAVIOUR
//  - Reset (sync, high): count=0, read/write pointers=0, RegWrite=0,
//    WriteReg=0, WriteData=0. in_ready=0 while reset high. Buffered entries
//    are discarded; no write is issued for them, including mid-drain.
//  - pop  = !wr_stall && count != 0 (combinational).
//  - in_ready = !reset && (count < DEPTH || pop). Push while full is legal
//    only when a pop occurs in the same cycle; count is unchanged.
//  - Accept = in_valid && in_ready. With in_reg == 0 the handshake completes
//    but nothing is enqueued. x0 never produces RegWrite.
//  - On each edge with pop: head entry goes to WriteReg/WriteData,
//    RegWrite=1, and the read pointer advances. Without pop: RegWrite=0, and
//    WriteReg/WriteData hold their last values.
//  - RegWrite is high for exactly one cycle per entry. The register file
//    commits on the following edge.
//  - Latency: accept at edge N into an empty FIFO with wr_stall=0 ->
//    RegWrite high from edge N+1 to N+2. The register file is updated at
//    edge N+2.
//  - Throughput: one write per cycle sustained. Order is strict FIFO; no
//    coalescing of same-index writes.
//  - Pointers wrap modulo DEPTH. count is updated as +1 on push only, -1 on
//    pop only, and 0 change on both.
//  - in_valid without in_ready: the producer holds in_reg/in_data stable.
//    The sequencer imposes no timeout.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//  - q_hit=1 when q_reg != 0 and it matches a valid FIFO entry, or the output
//    stage (RegWrite=1 && WriteReg==q_reg).
//  - q_data is taken from the youngest match, with FIFO entries younger than
//    the output stage.
//  - Purely combinational from current state. The same-cycle in_* push is
//    not included.
//  WB_BYPASS_EN undefined:
//  - q_reg is ignored; q_hit=0 and q_data=0 constantly.
//  - No comparator logic is built.
// TESTING
//  1 Push r5=0xDEADBEEF at edge N, stall=0 -> RegWrite=1, WriteReg=5,
//    WriteData=0xDEADBEEF only between edges N+1 and N+2.
//  2 stall=1, push r1..r4 (data 0x11..0x44) -> count=4, in_ready=0, fifth
//    push held. Release stall -> four consecutive RegWrite pulses, r1..r4
//    in order, then the fifth.
//  3 Push r0=0xFFFFFFFF -> handshake completes, count stays 0, RegWrite
//    stays 0.
//  4 WB_BYPASS_EN, stall=1, push r3=1 then r3=2 -> q_reg=3 gives q_hit=1,
//    q_data=2. q_reg=0 or 7 gives q_hit=0.
//  5 FIFO full, stall=0, in_valid=1 -> in_ready=1, accepted, count stays
//    4, head popped to RegWrite.
//  6 Three entries queued, stall=1, assert reset for 1 cycle -> count=0,
//    RegWrite=0. After stall drops, no write is issued for dropped entries.

Source files
------------

// File: rtl/regfile_wb_sequencer.sv
// regfile_wb_sequencer
//   Writeback-side initiator for the register file write port. Results arrive
//   on a valid/ready stream and are buffered in an in-order FIFO. The FIFO
//   drains at most one write per cycle onto the registered
//   RegWrite/WriteReg/WriteData outputs. Writes to x0 are accepted and then
//   dropped without being enqueued.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   : q_reg lookup reports the youngest pending write
//                 (q_hit/q_data) from the FIFO and the output stage.
//     undefined : no comparators are built; q_hit=0 and q_data=0.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_reg/in_data are the payload
//   wr_stall            holds the drain; no write is issued while high
//   RegWrite/WriteReg/WriteData  registered register-file write port
//   count, empty        FIFO occupancy
//   q_reg, q_hit, q_data  bypass lookup (active only with WB_BYPASS_EN)
module regfile_wb_sequencer #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_reg,
  input  logic [DW-1:0]          in_data,
  input  logic                   wr_stall,
  output logic                   RegWrite,
  output logic [AW-1:0]          WriteReg,
  output logic [DW-1:0]          WriteData,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  input  logic [AW-1:0]          q_reg,
  output logic                   q_hit,
  output logic [DW-1:0]          q_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] reg_mem_q  [DEPTH];
  logic [AW-1:0] reg_mem_d  [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [DW-1:0] data_mem_d [DEPTH];

  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] writereg_q, writereg_d;
  logic [DW-1:0] writedata_q, writedata_d;

  logic pop;
  logic accept;
  logic push;

  assign pop      = !wr_stall && (count_q != '0);
  // A full FIFO may still accept when the head drains in the same cycle.
  assign in_ready = !reset && ((count_q < CW'(DEPTH)) || pop);
  assign accept   = in_valid && in_ready;
  assign push     = accept && (in_reg != '0);

  always_comb begin
    reg_mem_d   = reg_mem_q;
    data_mem_d  = data_mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    regwrite_d  = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;

    if (push) begin
      reg_mem_d[wptr_q]  = in_reg;
      data_mem_d[wptr_q] = in_data;
      wptr_d             = wptr_q + 1'b1;
    end

    if (pop) begin
      regwrite_d  = 1'b1;
      writereg_d  = reg_mem_q[rptr_q];
      writedata_d = data_mem_q[rptr_q];
      rptr_d      = rptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
    end else begin
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    reg_mem_q  <= reg_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign RegWrite  = regwrite_q;
  assign WriteReg  = writereg_q;
  assign WriteData = writedata_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);

`ifdef WB_BYPASS_EN
  logic [PW-1:0] byp_idx;

  // Scan oldest to youngest so the last match wins; the output stage is
  // older than every FIFO entry, so it is considered first.
  always_comb begin
    q_hit   = 1'b0;
    q_data  = '0;
    byp_idx = rptr_q;
    if (q_reg != '0) begin
      if (regwrite_q && (writereg_q == q_reg)) begin
        q_hit  = 1'b1;
        q_data = writedata_q;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
        byp_idx = rptr_q + PW'(k);
        if ((CW'(k) < count_q) && (reg_mem_q[byp_idx] == q_reg)) begin
          q_hit  = 1'b1;
          q_data = data_mem_q[byp_idx];
        end
      end
    end
  end
`else
  logic unused_q_reg;
  assign unused_q_reg = ^q_reg;
  assign q_hit        = 1'b0;
  assign q_data       = '0;
`endif

endmodule
